// File: rtl/nrzi_rx.sv
// NRZI receiver: transition-coded line decode, sync hunt, bit destuffing and LSB-first word assembly.
// Optional RX_PARITY_EN: an even-parity bit follows each word and gates its commit.
module nrzi_rx #(
  parameter int          DATA_W    = 8,
  parameter int          STUFF_LEN = 6,
  parameter logic [7:0]  SYNC_PAT  = 8'hD5
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              rx_en,
  input  logic              bit_en,
  input  logic              line_in,
  input  logic              data_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              in_frame,
  output logic              stuff_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int BW = $clog2(DATA_W + 2);
  localparam int ZW = $clog2(STUFF_LEN + 1);
  localparam logic [ZW-1:0] ZMAX  = ZW'(STUFF_LEN);
  localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);
`ifdef RX_PARITY_EN
  localparam logic [BW-1:0] BPAR  = BW'(DATA_W);
`endif

  typedef enum logic {IDLE, DATA} state_t;

  state_t              state_q, state_d;
  logic                prev_line_q, prev_line_d;
  logic [7:0]          sync_sr_q, sync_sr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [ZW-1:0]       zcnt_q, zcnt_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                stuff_err_q, stuff_err_d;
  logic                overrun_q, overrun_d;
`ifdef RX_PARITY_EN
  logic                parity_err_q, parity_err_d;
`endif

  logic                bit_v;
  logic                commit;
  logic [DATA_W-1:0]   commit_word;

  always_comb begin
    state_d      = state_q;
    prev_line_d  = prev_line_q;
    sync_sr_d    = sync_sr_q;
    word_d       = word_q;
    bcnt_d       = bcnt_q;
    zcnt_d       = zcnt_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    stuff_err_d  = 1'b0;
    overrun_d    = 1'b0;
`ifdef RX_PARITY_EN
    parity_err_d = 1'b0;
`endif
    commit       = 1'b0;
    commit_word  = word_q;
    bit_v        = line_in ^ prev_line_q;

    // Line history tracks every sample so decode stays aligned across aborts.
    if (bit_en) prev_line_d = line_in;
    if (data_ack && data_valid_q) data_valid_d = 1'b0;

    if (!rx_en) begin
      state_d   = IDLE;
      sync_sr_d = '0;
      word_d    = '0;
      bcnt_d    = '0;
      zcnt_d    = '0;
    end else if (bit_en) begin
      case (state_q)
        IDLE: begin
          sync_sr_d = {bit_v, sync_sr_q[7:1]};
          if (sync_sr_d == SYNC_PAT) begin
            state_d = DATA;
            word_d  = '0;
            bcnt_d  = '0;
            zcnt_d  = '0;
          end
        end
        DATA: begin
          if (zcnt_q == ZMAX) begin
            if (bit_v) begin
              zcnt_d = '0;
            end else begin
              stuff_err_d = 1'b1;
              state_d     = IDLE;
              sync_sr_d   = '0;
              word_d      = '0;
              bcnt_d      = '0;
              zcnt_d      = '0;
            end
          end else begin
            zcnt_d = bit_v ? '0 : zcnt_q + 1'b1;
`ifdef RX_PARITY_EN
            if (bcnt_q == BPAR) begin
              bcnt_d = '0;
              if ((^word_q) ^ bit_v) parity_err_d = 1'b1;
              else begin
                commit      = 1'b1;
                commit_word = word_q;
              end
            end else begin
              word_d = {bit_v, word_q[DATA_W-1:1]};
              bcnt_d = bcnt_q + 1'b1;
            end
`else
            word_d = {bit_v, word_q[DATA_W-1:1]};
            if (bcnt_q == BLAST) begin
              bcnt_d      = '0;
              commit      = 1'b1;
              commit_word = word_d;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A fresh word always wins over a same-cycle ack.
    if (commit) begin
      data_out_d   = commit_word;
      data_valid_d = 1'b1;
      overrun_d    = data_valid_q && !data_ack;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_line_q  <= 1'b1;
      sync_sr_q    <= '0;
      word_q       <= '0;
      bcnt_q       <= '0;
      zcnt_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prev_line_q  <= prev_line_d;
      sync_sr_q    <= sync_sr_d;
      word_q       <= word_d;
      bcnt_q       <= bcnt_d;
      zcnt_q       <= zcnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      stuff_err_q  <= stuff_err_d;
      overrun_q    <= overrun_d;
`ifdef RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign in_frame   = (state_q == DATA);
  assign stuff_err  = stuff_err_q;
  assign overrun    = overrun_q;
`ifdef RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
